// File: rtl/sl_core_mem_slave.sv
// Memory-side responder for the Selen core request channel.
// Word RAM with byte/half/word access, fixed response latency and error flagging.
module sl_core_mem_slave #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  input  logic [2:0]  req_cop,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ack,
  output logic [31:0] req_ack_data,
  output logic        req_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [2:0] COP_READ  = 3'b000;
  localparam logic [2:0] COP_WRITE = 3'b001;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  lat_cop, lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic [2:0]    a_cop, a_size;
  logic [31:0]   a_addr, a_wdata;
  logic [3:0]    be;
  logic          bad_op, bad_size, misalign, in_range, acc_err, access;
  logic [32:0]   off;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  // With LATENCY=1 the access happens on the accepting edge, so decode the live inputs.
  always_comb begin
    a_cop   = (state == S_IDLE) ? req_cop   : lat_cop;
    a_size  = (state == S_IDLE) ? req_size  : lat_size;
    a_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    a_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  end

  always_comb begin
    be       = '0;
    misalign = 1'b0;
    bad_size = 1'b0;
    case (a_size)
      3'b000: be = 4'b0001 << a_addr[1:0];
      3'b001: begin
        be       = 4'b0011 << a_addr[1:0];
        misalign = a_addr[0];
      end
      3'b010: begin
        be       = 4'hF;
        misalign = |a_addr[1:0];
      end
      default: bad_size = 1'b1;
    endcase
    bad_op   = (a_cop != COP_READ) && (a_cop != COP_WRITE);
    off      = {1'b0, a_addr} - {1'b0, BASE_ADDR};
    in_range = (off < SPAN);
    idx      = off[AW+1:2];
    acc_err  = bad_op || bad_size || misalign || !in_range;
  end

  // WAIT lasts LATENCY-1 cycles: leave once the counter is about to reach zero.
  always_comb begin
    access = 1'b0;
    if (state == S_IDLE && req_val && LATENCY == 1)
      access = 1'b1;
    else if (state == S_WAIT && cnt == 4'd1)
      access = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req_ack      <= 1'b0;
      req_ack_data <= '0;
      req_err      <= 1'b0;
      lat_cop      <= '0;
      lat_size     <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      req_ack      <= 1'b0;
      req_ack_data <= '0;
      req_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_val) begin
            lat_cop   <= req_cop;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= 4'(LATENCY - 1);
            state     <= (LATENCY == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACK;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (access) begin
        req_ack      <= 1'b1;
        req_err      <= acc_err;
        req_ack_data <= (!acc_err && a_cop == COP_READ) ? mem[idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && access && !acc_err && a_cop == COP_WRITE) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end

  a_req_held: assert property (@(posedge clk) disable iff (rst) (state == S_WAIT) |-> req_val);

endmodule

// File: tb/tb_sl_core_mem_slave.sv
// Self-checking bench for sl_core_mem_slave: directed requests against a
// transaction-level memory model, checked every cycle.
module tb_sl_core_mem_slave;

  localparam int L     = 2;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic [2:0]  req_cop, req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ack;
  logic [31:0] req_ack_data;
  logic        req_err;

  sl_core_mem_slave #(.LATENCY(L), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_cop(req_cop), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .req_ack_data(req_ack_data), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          at;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  bit [31:0] mdl [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Transaction-level model: decide error, read value and memory update from the request alone.
  function automatic void model_push(input logic [2:0] cop, input logic [2:0] size,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input int at);
    exp_t   x;
    longint off;
    int     nb, lane, widx;
    x.at = at;
    x.d  = '0;
    x.e  = 1'b0;
    nb   = 1;
    off  = longint'(addr) - longint'(BASE);
    lane = int'(addr % 4);
    if (cop > 3'd1 || size > 3'd2) x.e = 1'b1;
    else begin
      nb = 1 << size;
      if ((addr % nb) != 0) x.e = 1'b1;
    end
    if (off < 0 || off >= longint'(DEPTH) * 4) x.e = 1'b1;
    if (!x.e) begin
      widx = int'(off / 4);
      if (cop == 3'd0) x.d = mdl[widx];
      else
        for (int b = 0; b < 4; b++)
          if (b >= lane && b < lane + nb) mdl[widx][8*b +: 8] = wdata[8*b +: 8];
    end
    exp_q.push_back(x);
  endfunction

  always @(negedge clk) begin
    logic        ea, ee;
    logic [31:0] ed;
    if (edge_cnt > 0) begin
      ea = 1'b0; ed = '0; ee = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].at < edge_cnt) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].at == edge_cnt) begin
        ea = 1'b1; ed = exp_q[0].d; ee = exp_q[0].e;
        void'(exp_q.pop_front());
      end
      chk("ack", {31'b0, req_ack}, {31'b0, ea});
      chk("ack_data", req_ack_data, ed);
      chk("err", {31'b0, req_err}, {31'b0, ee});
    end
  end

  // Called at a negedge; returns the ack payload and its latency in cycles.
  task automatic do_req(input logic [2:0] cop, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] d, output logic e,
                        output int lat);
    int start;
    start = edge_cnt;
    model_push(cop, size, addr, wdata, start + L);
    req_val = 1'b1; req_cop = cop; req_size = size; req_addr = addr; req_wdata = wdata;
    d = '0; e = 1'b0; lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (req_ack) begin
        d = req_ack_data; e = req_err; lat = edge_cnt - start;
      end
    end
    if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    req_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic b2b(input int n);
    int start, acks, last;
    start = edge_cnt;
    for (int k = 0; k < n; k++) model_push(3'd0, 3'd2, 32'h10, 32'h0, start + L + k * (L + 1));
    req_val = 1'b1; req_cop = 3'd0; req_size = 3'd2; req_addr = 32'h10; req_wdata = '0;
    acks = 0; last = 0;
    for (int i = 0; i < n * (L + 1) + 10 && acks < n; i++) begin
      @(posedge clk); #1;
      if (req_ack) begin
        if (acks > 0) chk("b2b_spacing", 32'(edge_cnt - last), 32'(L + 1));
        last = edge_cnt;
        acks++;
        if (acks == n) req_val = 1'b0;
      end
    end
    req_val = 1'b0;
    chk("b2b_count", 32'(acks), 32'(n));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_in_wait();
    int acks;
    req_val = 1'b1; req_cop = 3'd1; req_size = 3'd2; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_val = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (req_ack) acks++;
    end
    chk("rst_noack", 32'(acks), 32'd0);
    @(negedge clk);
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;

  initial begin
    rst = 1'b1; req_val = 1'b0; req_cop = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, req_ack}, 32'd0);
    chk("rst_data", req_ack_data, 32'd0);
    chk("rst_err", {31'b0, req_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_req(3'd1, 3'd2, 32'h10, 32'hDEADBEEF, d, e, lat);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_err", {31'b0, e}, 32'd0);
    chk("t1_wdata0", d, 32'd0);
    do_req(3'd0, 3'd2, 32'h10, 32'h0, d, e, lat);
    chk("t1_read", d, 32'hDEADBEEF);

    do_req(3'd1, 3'd0, 32'h13, 32'hAA000000, d, e, lat);
    do_req(3'd0, 3'd2, 32'h10, 32'h0, d, e, lat);
    chk("t2_read", d, 32'hAAADBEEF);

    do_req(3'd1, 3'd1, 32'h11, 32'h00FFFF00, d, e, lat);
    chk("t3_err", {31'b0, e}, 32'd1);
    chk("t3_data", d, 32'd0);
    do_req(3'd0, 3'd1, 32'h10, 32'h0, d, e, lat);
    chk("t3_read", d, 32'hAAADBEEF);

    do_req(3'd1, 3'd1, 32'h12, 32'h12340000, d, e, lat);
    do_req(3'd0, 3'd0, 32'h11, 32'h0, d, e, lat);
    chk("half_read", d, 32'h1234BEEF);

    do_req(3'd0, 3'd2, 32'h1000, 32'h0, d, e, lat);
    chk("t4_range", {31'b0, e}, 32'd1);
    do_req(3'd7, 3'd2, 32'h10, 32'h0, d, e, lat);
    chk("t4_cop", {31'b0, e}, 32'd1);
    do_req(3'd0, 3'd3, 32'h10, 32'h0, d, e, lat);
    chk("t4_size", {31'b0, e}, 32'd1);
    do_req(3'd1, 3'd2, 32'hFFC, 32'h55667788, d, e, lat);
    do_req(3'd0, 3'd2, 32'hFFC, 32'h0, d, e, lat);
    chk("top_word_err", {31'b0, e}, 32'd0);
    chk("top_word", d, 32'h55667788);
    do_req(3'd1, 3'd2, 32'h12, 32'h0, d, e, lat);
    chk("word_misalign", {31'b0, e}, 32'd1);

    b2b(3);

    rst_in_wait();
    do_req(3'd0, 3'd2, 32'h10, 32'h0, d, e, lat);
    chk("t6_read", d, 32'h1234BEEF);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
